mem_req_demux2: RTL and testbench

- Routes one upstream memory request stream from the CPU core to one of two downstream targets by address.
  - Port 0: cached path (cache controller).
  - Port 1: uncached path (MMIO / peripherals).
- Register-sliced, single-outstanding-request splitter with a handshake on every side and a timeout guard.
- Sits between the CPU memory stage and the cache / MMIO bus. It is the distributing counterpart of the 2:1 data-path selector.

---
 rtl/mem_req_demux2_if.sv | 52 +++++
 rtl/mem_req_demux2.sv | 180 ++++++++++++++++++
 tb/tb_mem_req_demux2.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_demux2_if.sv
// mem_req_demux2_if
// Bundles the upstream request channel (u_*) and the two downstream channels
// (d0_* cached path, d1_* uncached path) of the request demultiplexer.
//   slave  : the demux itself (accepts u_*, drives d0_*/d1_* requests)
//   master : the surrounding core / target side (drives u_* requests and
//            d0_*/d1_* completions)
interface mem_req_demux2_if;
    // upstream channel
    logic        u_req;
    logic [31:0] u_addr;
    logic        u_we;
    logic [31:0] u_wdata;
    logic [3:0]  u_wmask;
    logic        u_ready;
    logic        u_ack;
    logic [31:0] u_rdata;
    logic        u_err;
    // downstream port 0 (cached)
    logic        d0_req;
    logic [31:0] d0_addr;
    logic        d0_we;
    logic [31:0] d0_wdata;
    logic [3:0]  d0_wmask;
    logic        d0_ack;
    logic [31:0] d0_rdata;
    // downstream port 1 (uncached / MMIO)
    logic        d1_req;
    logic [31:0] d1_addr;
    logic        d1_we;
    logic [31:0] d1_wdata;
    logic [3:0]  d1_wmask;
    logic        d1_ack;
    logic [31:0] d1_rdata;

    modport slave (
        input  u_req, u_addr, u_we, u_wdata, u_wmask,
        output u_ready, u_ack, u_rdata, u_err,
        output d0_req, d0_addr, d0_we, d0_wdata, d0_wmask,
        input  d0_ack, d0_rdata,
        output d1_req, d1_addr, d1_we, d1_wdata, d1_wmask,
        input  d1_ack, d1_rdata
    );

    modport master (
        output u_req, u_addr, u_we, u_wdata, u_wmask,
        input  u_ready, u_ack, u_rdata, u_err,
        input  d0_req, d0_addr, d0_we, d0_wdata, d0_wmask,
        output d0_ack, d0_rdata,
        input  d1_req, d1_addr, d1_we, d1_wdata, d1_wmask,
        output d1_ack, d1_rdata
    );
endinterface

// File: rtl/mem_req_demux2.sv
// mem_req_demux2
// Single-outstanding-request splitter: routes one upstream memory request to
// the cached port (d0) or the uncached/MMIO port (d1) by address, waits for
// the downstream ack (bounded by a timeout) and returns a one-cycle u_ack.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_req_demux2_if.slave: u_* upstream, d0_*/d1_* downstream
// Every output is a flop; the next value of each is decoded from the
// next state so the timing matches a state-decoded design.
module mem_req_demux2 #(
    parameter logic [31:0] UNCACHED_BASE = 32'hF000_0000,
    parameter int          TIMEOUT       = 255,
    parameter logic [31:0] ERR_DATA      = 32'hDEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_req_demux2_if.slave        bus
);

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             load_s;
    logic             dn_ack_s;
    logic [31:0]      dn_rdata_s;
    logic [31:0]      rdata_r;
    logic [31:0]      rdata_nxt_s;
    logic             err_r;
    logic             err_nxt_s;
    logic             ack_r;
    logic             ready_r;
    logic             d0_req_r;
    logic             d1_req_r;
    logic [31:0]      addr_r;
    logic             we_r;
    logic [31:0]      wdata_r;
    logic [3:0]       wmask_r;

    // Selects the ack/data of the port currently being served; the other
    // port's ack is deliberately not looked at.
    always_comb begin
        dn_ack_s   = 1'b0;
        dn_rdata_s = 32'h0000_0000;
        if (state_r == BUSY0) begin
            dn_ack_s   = bus.d0_ack;
            dn_rdata_s = bus.d0_rdata;
        end else if (state_r == BUSY1) begin
            dn_ack_s   = bus.d1_ack;
            dn_rdata_s = bus.d1_rdata;
        end else begin
            dn_ack_s   = 1'b0;
            dn_rdata_s = 32'h0000_0000;
        end
    end

    // Next-state, counter and response-capture logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rdata_nxt_s = rdata_r;
        err_nxt_s   = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.u_req) begin
                    load_s      = 1'b1;
                    state_nxt_s = (bus.u_addr >= UNCACHED_BASE) ? BUSY1 : BUSY0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY0, BUSY1: begin
                // Ack is checked first so a coincident expiry still returns data.
                if (dn_ack_s) begin
                    rdata_nxt_s = dn_rdata_s;
                    err_nxt_s   = 1'b0;
                    state_nxt_s = RESP;
                end else if (cnt_r == CNT_LAST) begin
                    rdata_nxt_s = ERR_DATA;
                    err_nxt_s   = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            RESP: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = IDLE;
            end
            default: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Request payload: sampled only at the accept edge, held through BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= 32'h0000_0000;
            we_r    <= 1'b0;
            wdata_r <= 32'h0000_0000;
            wmask_r <= 4'b0000;
        end else if (load_s) begin
            addr_r  <= bus.u_addr;
            we_r    <= bus.u_we;
            wdata_r <= bus.u_wdata;
            wmask_r <= bus.u_wmask;
        end else begin
            addr_r  <= addr_r;
            we_r    <= we_r;
            wdata_r <= wdata_r;
            wmask_r <= wmask_r;
        end
    end

    // Registered handshake outputs decoded from the next state; u_rdata keeps
    // its last value outside RESP while u_err is only high in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r  <= 32'h0000_0000;
            err_r    <= 1'b0;
            ack_r    <= 1'b0;
            ready_r  <= 1'b1;
            d0_req_r <= 1'b0;
            d1_req_r <= 1'b0;
        end else begin
            rdata_r  <= rdata_nxt_s;
            err_r    <= err_nxt_s;
            ack_r    <= (state_nxt_s == RESP);
            ready_r  <= (state_nxt_s == IDLE);
            d0_req_r <= (state_nxt_s == BUSY0);
            d1_req_r <= (state_nxt_s == BUSY1);
        end
    end

    assign bus.u_ready  = ready_r;
    assign bus.u_ack    = ack_r;
    assign bus.u_rdata  = rdata_r;
    assign bus.u_err    = err_r;

    assign bus.d0_req   = d0_req_r;
    assign bus.d0_addr  = addr_r;
    assign bus.d0_we    = we_r;
    assign bus.d0_wdata = wdata_r;
    assign bus.d0_wmask = wmask_r;

    assign bus.d1_req   = d1_req_r;
    assign bus.d1_addr  = addr_r;
    assign bus.d1_we    = we_r;
    assign bus.d1_wdata = wdata_r;
    assign bus.d1_wmask = wmask_r;

endmodule

// File: tb/tb_mem_req_demux2.sv
// tb_mem_req_demux2
// Directed bench for mem_req_demux2. dut_a uses the default TIMEOUT (255)
// for routing / long-ack / reset scenarios; dut_b uses TIMEOUT = 4 for the
// timeout scenarios. Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point.
module tb_mem_req_demux2;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mem_req_demux2_if bus_a ();
    mem_req_demux2_if bus_b ();

    mem_req_demux2 dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mem_req_demux2 #(.TIMEOUT(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus_a.u_ready !== 1'b1) begin errors++; $display("FAIL reset_u_ready: got %b expected 1", bus_a.u_ready); end
        checks++; if (bus_a.u_ack !== 1'b0) begin errors++; $display("FAIL reset_u_ack: got %b expected 0", bus_a.u_ack); end
        checks++; if (bus_a.u_err !== 1'b0) begin errors++; $display("FAIL reset_u_err: got %b expected 0", bus_a.u_err); end
        checks++; if (bus_a.u_rdata !== 32'h0000_0000) begin errors++; $display("FAIL reset_u_rdata: got %h expected 00000000", bus_a.u_rdata); end
        checks++; if ({bus_a.d0_req, bus_a.d1_req} !== 2'b00) begin errors++; $display("FAIL reset_dreq: got %b expected 00", {bus_a.d0_req, bus_a.d1_req}); end
        checks++; if ({bus_a.d0_addr, bus_a.d0_wdata, bus_a.d0_wmask, bus_a.d0_we} !== 69'd0) begin errors++; $display("FAIL reset_payload: got %h/%h/%b/%b expected zeros", bus_a.d0_addr, bus_a.d0_wdata, bus_a.d0_wmask, bus_a.d0_we); end
        checks++; if (bus_b.u_ready !== 1'b1) begin errors++; $display("FAIL reset_b_u_ready: got %b expected 1", bus_b.u_ready); end
    endtask

    // Test plan 1: read on port 0 with immediate ack.
    task automatic test_read_port0;
        bus_a.u_req = 1'b1; bus_a.u_addr = 32'h0000_1000; bus_a.u_we = 1'b0;
        bus_a.u_wdata = 32'h0000_0000; bus_a.u_wmask = 4'b0000;
        tick();
        bus_a.u_req = 1'b0;
        checks++; if ({bus_a.d0_req, bus_a.d1_req} !== 2'b10) begin errors++; $display("FAIL rd0_dreq: got %b expected 10", {bus_a.d0_req, bus_a.d1_req}); end
        checks++; if (bus_a.d0_addr !== 32'h0000_1000 || bus_a.d0_we !== 1'b0) begin errors++; $display("FAIL rd0_payload: got %h we=%b expected 00001000 we=0", bus_a.d0_addr, bus_a.d0_we); end
        checks++; if (bus_a.u_ready !== 1'b0 || bus_a.u_ack !== 1'b0) begin errors++; $display("FAIL rd0_busy_up: got ready=%b ack=%b expected 0 0", bus_a.u_ready, bus_a.u_ack); end
        bus_a.d0_ack = 1'b1; bus_a.d0_rdata = 32'h1234_5678;
        tick();
        bus_a.d0_ack = 1'b0; bus_a.d0_rdata = 32'h0000_0000;
        checks++; if (bus_a.u_ack !== 1'b1 || bus_a.u_err !== 1'b0) begin errors++; $display("FAIL rd0_ack: got ack=%b err=%b expected 1 0", bus_a.u_ack, bus_a.u_err); end
        checks++; if (bus_a.u_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd0_rdata: got %h expected 12345678", bus_a.u_rdata); end
        checks++; if ({bus_a.d0_req, bus_a.d1_req, bus_a.u_ready} !== 3'b000) begin errors++; $display("FAIL rd0_resp_state: got %b expected 000", {bus_a.d0_req, bus_a.d1_req, bus_a.u_ready}); end
        tick();
        checks++; if (bus_a.u_ack !== 1'b0 || bus_a.u_ready !== 1'b1) begin errors++; $display("FAIL rd0_idle: got ack=%b ready=%b expected 0 1", bus_a.u_ack, bus_a.u_ready); end
        checks++; if (bus_a.u_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd0_rdata_hold: got %h expected 12345678", bus_a.u_rdata); end
    endtask

    // Test plan 2: write on port 1 at the boundary, ack after 5 wait cycles,
    // then the address just below the boundary routed to port 0.
    task automatic test_write_port1;
        bus_a.u_req = 1'b1; bus_a.u_addr = 32'hF000_0000; bus_a.u_we = 1'b1;
        bus_a.u_wdata = 32'hA5A5_A5A5; bus_a.u_wmask = 4'b0011;
        tick();
        // Later upstream changes must not leak into the latched payload.
        bus_a.u_req = 1'b0; bus_a.u_addr = 32'h0BAD_0BAD; bus_a.u_we = 1'b0;
        bus_a.u_wdata = 32'h5A5A_5A5A; bus_a.u_wmask = 4'b1100;
        for (int i = 0; i < 6; i++) begin
            checks++; if ({bus_a.d0_req, bus_a.d1_req, bus_a.u_ack} !== 3'b010) begin errors++; $display("FAIL wr1_dreq cyc%0d: got %b expected 010", i, {bus_a.d0_req, bus_a.d1_req, bus_a.u_ack}); end
            checks++; if (bus_a.d1_addr !== 32'hF000_0000 || bus_a.d1_we !== 1'b1 || bus_a.d1_wdata !== 32'hA5A5_A5A5 || bus_a.d1_wmask !== 4'b0011) begin
                errors++; $display("FAIL wr1_payload cyc%0d: got %h %b %h %b expected F0000000 1 A5A5A5A5 0011", i, bus_a.d1_addr, bus_a.d1_we, bus_a.d1_wdata, bus_a.d1_wmask);
            end
            if (i == 5) begin
                bus_a.d1_ack = 1'b1; bus_a.d1_rdata = 32'h0000_00AA;
            end
            tick();
        end
        bus_a.d1_ack = 1'b0;
        checks++; if (bus_a.u_ack !== 1'b1 || bus_a.u_err !== 1'b0 || bus_a.d1_req !== 1'b0) begin errors++; $display("FAIL wr1_ack: got ack=%b err=%b d1_req=%b expected 1 0 0", bus_a.u_ack, bus_a.u_err, bus_a.d1_req); end
        tick();
        bus_a.u_req = 1'b1; bus_a.u_addr = 32'hEFFF_FFFC; bus_a.u_we = 1'b1;
        bus_a.u_wdata = 32'hA5A5_A5A5; bus_a.u_wmask = 4'b0011;
        tick();
        bus_a.u_req = 1'b0;
        checks++; if ({bus_a.d0_req, bus_a.d1_req} !== 2'b10 || bus_a.d0_addr !== 32'hEFFF_FFFC) begin errors++; $display("FAIL wr0_route: got req=%b addr=%h expected 10 EFFFFFFC", {bus_a.d0_req, bus_a.d1_req}, bus_a.d0_addr); end
        bus_a.d0_ack = 1'b1;
        tick();
        bus_a.d0_ack = 1'b0;
        checks++; if (bus_a.u_ack !== 1'b1) begin errors++; $display("FAIL wr0_ack: got %b expected 1", bus_a.u_ack); end
        tick();
    endtask

    // Routing at and around the uncached base address.
    task automatic test_boundary;
        logic [31:0] addrs [4];
        logic        port1 [4];
        addrs = '{32'hEFFF_FFFF, 32'hF000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        port1 = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            bus_a.u_req = 1'b1; bus_a.u_addr = addrs[i]; bus_a.u_we = 1'b0;
            tick();
            bus_a.u_req = 1'b0;
            checks++; if ({bus_a.d0_req, bus_a.d1_req} !== {~port1[i], port1[i]}) begin errors++; $display("FAIL route %h: got %b expected %b", addrs[i], {bus_a.d0_req, bus_a.d1_req}, {~port1[i], port1[i]}); end
            if (port1[i]) bus_a.d1_ack = 1'b1; else bus_a.d0_ack = 1'b1;
            tick();
            bus_a.d0_ack = 1'b0; bus_a.d1_ack = 1'b0;
            checks++; if (bus_a.u_ack !== 1'b1) begin errors++; $display("FAIL route_ack %h: got %b expected 1", addrs[i], bus_a.u_ack); end
            tick();
        end
    endtask

    // Test plan 3: timeout on port 1 (TIMEOUT = 4), late ack ignored.
    task automatic test_timeout;
        bus_b.u_req = 1'b1; bus_b.u_addr = 32'hF000_0010; bus_b.u_we = 1'b0;
        tick();
        bus_b.u_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({bus_b.d1_req, bus_b.u_ack} !== 2'b10) begin errors++; $display("FAIL to_busy cyc%0d: got %b expected 10", i, {bus_b.d1_req, bus_b.u_ack}); end
            tick();
        end
        checks++; if (bus_b.u_ack !== 1'b1 || bus_b.u_err !== 1'b1) begin errors++; $display("FAIL to_ack: got ack=%b err=%b expected 1 1", bus_b.u_ack, bus_b.u_err); end
        checks++; if (bus_b.u_rdata !== 32'hDEAD_BEEF || bus_b.d1_req !== 1'b0) begin errors++; $display("FAIL to_rdata: got %h d1_req=%b expected DEADBEEF 0", bus_b.u_rdata, bus_b.d1_req); end
        bus_b.d1_ack = 1'b1; bus_b.d1_rdata = 32'h1111_1111;
        tick();
        checks++; if ({bus_b.u_ack, bus_b.u_err, bus_b.u_ready} !== 3'b001) begin errors++; $display("FAIL to_late1: got %b expected 001", {bus_b.u_ack, bus_b.u_err, bus_b.u_ready}); end
        tick();
        bus_b.d1_ack = 1'b0;
        checks++; if ({bus_b.u_ack, bus_b.d1_req} !== 2'b00 || bus_b.u_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_late2: got ack/req=%b rdata=%h expected 00 DEADBEEF", {bus_b.u_ack, bus_b.d1_req}, bus_b.u_rdata); end
    endtask

    // Test plan 4: ack in the same cycle as expiry wins.
    task automatic test_ack_at_expiry;
        bus_b.u_req = 1'b1; bus_b.u_addr = 32'h0000_2000; bus_b.u_we = 1'b0;
        tick();
        bus_b.u_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({bus_b.d0_req, bus_b.u_ack} !== 2'b10) begin errors++; $display("FAIL coin_busy cyc%0d: got %b expected 10", i, {bus_b.d0_req, bus_b.u_ack}); end
            if (i == 3) begin
                bus_b.d0_ack = 1'b1; bus_b.d0_rdata = 32'hCAFE_F00D;
            end
            tick();
        end
        bus_b.d0_ack = 1'b0;
        checks++; if (bus_b.u_ack !== 1'b1 || bus_b.u_err !== 1'b0 || bus_b.u_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL coin_resp: got ack=%b err=%b rdata=%h expected 1 0 CAFEF00D", bus_b.u_ack, bus_b.u_err, bus_b.u_rdata); end
        tick();
    endtask

    // Test plan 5: wrong-port ack, upstream request during BUSY, ack in IDLE.
    task automatic test_spurious;
        bus_a.u_req = 1'b1; bus_a.u_addr = 32'h0000_3000; bus_a.u_we = 1'b1;
        bus_a.u_wdata = 32'h1111_2222; bus_a.u_wmask = 4'b1111;
        tick();
        bus_a.u_addr = 32'hF000_0100; bus_a.u_wdata = 32'h3333_4444;
        bus_a.d1_ack = 1'b1; bus_a.d1_rdata = 32'h0000_0BAD;
        tick();
        bus_a.d1_ack = 1'b0;
        checks++; if ({bus_a.d0_req, bus_a.d1_req, bus_a.u_ack, bus_a.u_ready} !== 4'b1000) begin errors++; $display("FAIL sp_state: got %b expected 1000", {bus_a.d0_req, bus_a.d1_req, bus_a.u_ack, bus_a.u_ready}); end
        checks++; if (bus_a.d0_addr !== 32'h0000_3000 || bus_a.d0_wdata !== 32'h1111_2222) begin errors++; $display("FAIL sp_payload: got %h %h expected 00003000 11112222", bus_a.d0_addr, bus_a.d0_wdata); end
        bus_a.u_req = 1'b0;
        bus_a.d0_ack = 1'b1; bus_a.d0_rdata = 32'h0000_0055;
        tick();
        bus_a.d0_ack = 1'b0;
        checks++; if (bus_a.u_ack !== 1'b1 || bus_a.u_rdata !== 32'h0000_0055) begin errors++; $display("FAIL sp_ack: got ack=%b rdata=%h expected 1 00000055", bus_a.u_ack, bus_a.u_rdata); end
        tick();
        checks++; if (bus_a.u_ack !== 1'b0) begin errors++; $display("FAIL sp_single_ack: got %b expected 0", bus_a.u_ack); end
        bus_a.d0_ack = 1'b1; bus_a.d0_rdata = 32'h0000_0066;
        tick();
        bus_a.d0_ack = 1'b0;
        checks++; if ({bus_a.u_ack, bus_a.u_ready, bus_a.d0_req} !== 3'b010 || bus_a.u_rdata !== 32'h0000_0055) begin errors++; $display("FAIL sp_idle_ack: got %b rdata=%h expected 010 00000055", {bus_a.u_ack, bus_a.u_ready, bus_a.d0_req}, bus_a.u_rdata); end
    endtask

    // Test plan 6: reset in the 2nd BUSY cycle, then a normal request.
    task automatic test_reset_mid;
        bus_a.u_req = 1'b1; bus_a.u_addr = 32'h0000_4000; bus_a.u_we = 1'b0;
        tick();
        bus_a.u_req = 1'b0;
        checks++; if (bus_a.d0_req !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b expected 1", bus_a.d0_req); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus_a.d0_req, bus_a.d1_req, bus_a.u_ack, bus_a.u_ready} !== 4'b0001) begin errors++; $display("FAIL rm_after: got %b expected 0001", {bus_a.d0_req, bus_a.d1_req, bus_a.u_ack, bus_a.u_ready}); end
        checks++; if (bus_a.d0_addr !== 32'h0000_0000) begin errors++; $display("FAIL rm_payload: got %h expected 00000000", bus_a.d0_addr); end
        tick();
        checks++; if (bus_a.u_ack !== 1'b0) begin errors++; $display("FAIL rm_no_ack: got %b expected 0", bus_a.u_ack); end
        bus_a.u_req = 1'b1; bus_a.u_addr = 32'hF000_0004; bus_a.u_we = 1'b0;
        tick();
        bus_a.u_req = 1'b0;
        bus_a.d1_ack = 1'b1; bus_a.d1_rdata = 32'h0000_0077;
        tick();
        bus_a.d1_ack = 1'b0;
        checks++; if (bus_a.u_ack !== 1'b1 || bus_a.u_rdata !== 32'h0000_0077 || bus_a.u_err !== 1'b0) begin errors++; $display("FAIL rm_resume: got ack=%b rdata=%h err=%b expected 1 00000077 0", bus_a.u_ack, bus_a.u_rdata, bus_a.u_err); end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus_a.u_req = 1'b0; bus_a.u_addr = 32'h0; bus_a.u_we = 1'b0;
        bus_a.u_wdata = 32'h0; bus_a.u_wmask = 4'b0000;
        bus_a.d0_ack = 1'b0; bus_a.d0_rdata = 32'h0;
        bus_a.d1_ack = 1'b0; bus_a.d1_rdata = 32'h0;
        bus_b.u_req = 1'b0; bus_b.u_addr = 32'h0; bus_b.u_we = 1'b0;
        bus_b.u_wdata = 32'h0; bus_b.u_wmask = 4'b0000;
        bus_b.d0_ack = 1'b0; bus_b.d0_rdata = 32'h0;
        bus_b.d1_ack = 1'b0; bus_b.d1_rdata = 32'h0;

        test_reset();
        test_read_port0();
        test_write_port1();
        test_boundary();
        test_timeout();
        test_ack_at_expiry();
        test_spurious();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
